// File: rtl/rob_wb_arb.sv
// ROB writeback arbiter: per-source result FIFOs drained round-robin into a single
// registered write port toward the ROB. A mispredict flush empties FIFOs and output stage.
module rob_wb_arb #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned RES_W      = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_rb1,
    input  logic [NUM_SRC-1:0]         src_valid_nn0,
    input  logic [NUM_SRC*RES_W-1:0]   src_result_nn0,
    output logic [NUM_SRC-1:0]         src_stall_nn0,
    input  logic                       ro_ready_rb0,
    output logic                       ro_valid_rb0,
    output logic [RES_W-1:0]           ro_result_rb0,
    output logic [$clog2(NUM_SRC)-1:0] ro_src_rb0,
    output logic                       err_overflow
);

    typedef int unsigned uint_t;

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(FIFO_DEPTH - 1);

    logic [RES_W-1:0]                mem_q [NUM_SRC][FIFO_DEPTH];
    logic [NUM_SRC-1:0][PTR_W-1:0]   wr_ptr_q;
    logic [NUM_SRC-1:0][PTR_W-1:0]   rd_ptr_q;
    logic [NUM_SRC-1:0][CNT_W-1:0]   cnt_q;
    logic [SRC_W-1:0]                rr_ptr_q;
    logic                            ro_valid_q;
    logic [RES_W-1:0]                ro_result_q;
    logic [SRC_W-1:0]                ro_src_q;
    logic                            err_q;

    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] push_en;
    logic [NUM_SRC-1:0] pop_en;
    logic [NUM_SRC-1:0] drop;
    logic               load;
    logic               win_found;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   cand_idx;
    logic [SRC_W-1:0]   rr_next;
    logic [RES_W-1:0]   head;

    assign ro_valid_rb0  = ro_valid_q;
    assign ro_result_rb0 = ro_result_q;
    assign ro_src_rb0    = ro_src_q;
    assign err_overflow  = err_q;

    // Output stage accepts a new entry when empty or when the ROB takes the current one.
    assign load = !ro_valid_q || ro_ready_rb0;

    // Per-source status decoded from the count flops.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            nonempty[i]      = (cnt_q[i] != '0);
            src_stall_nn0[i] = (cnt_q[i] >= CNT_STALL);
        end
    end

    // Round-robin pick: first non-empty FIFO scanning from rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand_idx = SRC_W'((uint_t'(rr_ptr_q) + k) % NUM_SRC);
            if (!win_found && nonempty[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        rr_next = SRC_W'((uint_t'(win_idx) + 1) % NUM_SRC);
        head    = mem_q[win_idx][rd_ptr_q[win_idx]];
    end

    // Push/pop qualification; flush cancels both, and a full FIFO only accepts with a pop.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pop_en[i]  = load && win_found && (win_idx == SRC_W'(i)) && !flush_rb1;
            drop[i]    = src_valid_nn0[i] && !flush_rb1 && (cnt_q[i] == CNT_FULL) && !pop_en[i];
            push_en[i] = src_valid_nn0[i] && !flush_rb1 && !drop[i];
        end
    end

    // FIFO storage write; contents need no reset since counts gate visibility.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (push_en[i]) begin
                mem_q[i][wr_ptr_q[i]] <= src_result_nn0[i*RES_W +: RES_W];
            end
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk) begin
        if (reset || flush_rb1) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (push_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop_en[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                if (push_en[i] && !pop_en[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (!push_en[i] && pop_en[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Output register, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ro_valid_q  <= 1'b0;
            ro_result_q <= '0;
            ro_src_q    <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            if (|drop) err_q <= 1'b1;
            if (flush_rb1) begin
                ro_valid_q <= 1'b0;
            end else if (load) begin
                ro_valid_q <= win_found;
                if (win_found) begin
                    ro_result_q <= head;
                    ro_src_q    <= win_idx;
                    rr_ptr_q    <= rr_next;
                end
            end
        end
    end

    // Runtime checks: storage is never written while full without a pop, and a
    // stalled output keeps valid, result and source unchanged.
    logic             hold_q;
    logic [RES_W-1:0] hold_res_q;
    logic [SRC_W-1:0] hold_src_q;

    // Capture the output values that must persist into the next cycle.
    always_ff @(posedge clk) begin
        hold_q     <= !reset && !flush_rb1 && ro_valid_q && !ro_ready_rb0;
        hold_res_q <= ro_result_q;
        hold_src_q <= ro_src_q;
        if (hold_q) begin
            assert (ro_valid_q && (ro_result_q == hold_res_q) && (ro_src_q == hold_src_q));
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!reset) assert (!(push_en[i] && (cnt_q[i] == CNT_FULL) && !pop_en[i]));
        end
    end

endmodule

// File: tb/tb_rob_wb_arb.sv
// Self-checking bench for rob_wb_arb: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based reference model.
module tb_rob_wb_arb;

    localparam int NS    = 2;
    localparam int RW    = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush_rb1;
    logic [NS-1:0]   src_valid_nn0;
    logic [NS*RW-1:0] src_result_nn0;
    logic [NS-1:0]   src_stall_nn0;
    logic            ro_ready_rb0;
    logic            ro_valid_rb0;
    logic [RW-1:0]   ro_result_rb0;
    logic            ro_src_rb0;
    logic            err_overflow;

    rob_wb_arb #(.NUM_SRC(NS), .RES_W(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_rb1      (flush_rb1),
        .src_valid_nn0  (src_valid_nn0),
        .src_result_nn0 (src_result_nn0),
        .src_stall_nn0  (src_stall_nn0),
        .ro_ready_rb0   (ro_ready_rb0),
        .ro_valid_rb0   (ro_valid_rb0),
        .ro_result_rb0  (ro_result_rb0),
        .ro_src_rb0     (ro_src_rb0),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    logic [RW-1:0] mq [NS][$];
    logic          m_valid;
    logic [RW-1:0] m_res;
    int            m_src;
    int            m_rr;
    logic          m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int   psrc;
        logic load;
        logic [NS-1:0] dropped;
        logic [RW-1:0] d [NS];
        for (int s = 0; s < NS; s++) d[s] = src_result_nn0[s*RW +: RW];
        if (reset) begin
            for (int s = 0; s < NS; s++) mq[s].delete();
            m_valid = 0; m_res = '0; m_src = 0; m_rr = 0; m_err = 0;
            return;
        end
        if (flush_rb1) begin
            for (int s = 0; s < NS; s++) mq[s].delete();
            m_valid = 0;
            return;
        end
        load = !m_valid || ro_ready_rb0;
        psrc = -1;
        if (load) begin
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (m_rr + k) % NS;
                if (psrc < 0 && mq[s].size() > 0) psrc = s;
            end
        end
        for (int s = 0; s < NS; s++) begin
            dropped[s] = src_valid_nn0[s] && (mq[s].size() == DEPTH) && (psrc != s);
            if (dropped[s]) m_err = 1;
        end
        if (load) begin
            m_valid = (psrc >= 0);
            if (psrc >= 0) begin
                m_res = mq[psrc].pop_front();
                m_src = psrc;
                m_rr  = (psrc + 1) % NS;
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (src_valid_nn0[s] && !dropped[s]) mq[s].push_back(d[s]);
        end
    endtask

    task automatic compare_all();
        check("valid", 64'(ro_valid_rb0), 64'(m_valid));
        check("result", ro_result_rb0, m_res);
        check("src", 64'(ro_src_rb0), 64'(m_src));
        for (int s = 0; s < NS; s++) begin
            check($sformatf("stall%0d", s), 64'(src_stall_nn0[s]), 64'(mq[s].size() >= DEPTH - 1));
        end
        check("err", 64'(err_overflow), 64'(m_err));
    endtask

    task automatic cyc(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                       input logic r, input logic f, input logic rs);
        src_valid_nn0  = v;
        src_result_nn0 = {b, a};
        ro_ready_rb0   = r;
        flush_rb1      = f;
        reset          = rs;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic r);
        cyc(2'b00, 64'h0, 64'h0, r, 1'b0, 1'b0);
    endtask

    initial begin
        int   seen_stall;
        int   repeats;
        int   last_src;
        logic [1:0] v;

        cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);
        cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);
        check("rst_valid", 64'(ro_valid_rb0), 64'h0);
        check("rst_result", ro_result_rb0, 64'h0);
        check("rst_err", 64'(err_overflow), 64'h0);
        for (int i = 0; i < 7; i++) idle(1'b1);

        // Single push: visible exactly two cycles after the push.
        cyc(2'b01, 64'hA5, 0, 1'b1, 1'b0, 1'b0);
        check("t1_lat1", 64'(ro_valid_rb0), 64'h0);
        idle(1'b1);
        check("t1_valid", 64'(ro_valid_rb0), 64'h1);
        check("t1_res", ro_result_rb0, 64'hA5);
        check("t1_src", 64'(ro_src_rb0), 64'h0);
        idle(1'b1);
        check("t1_once", 64'(ro_valid_rb0), 64'h0);

        // Fairness: both sources push every cycle unless stalled.
        seen_stall = 0; repeats = 0; last_src = -1;
        for (int i = 0; i < 24; i++) begin
            v[0] = (mq[0].size() < DEPTH - 1);
            v[1] = (mq[1].size() < DEPTH - 1);
            cyc(v, 64'h100 + 64'(i), 64'h200 + 64'(i), 1'b1, 1'b0, 1'b0);
            if (src_stall_nn0 != 0) seen_stall = 1;
            if (ro_valid_rb0) begin
                if (last_src == int'(ro_src_rb0)) repeats++;
                last_src = int'(ro_src_rb0);
            end
        end
        check("t2_stall_seen", 64'(seen_stall), 64'h1);
        check("t2_alternate", 64'(repeats), 64'h0);
        check("t2_no_ovf", 64'(err_overflow), 64'h0);
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Backpressure: four results into src1 while the ROB is not ready.
        for (int i = 0; i < 4; i++) cyc(2'b10, 0, 64'h300 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle(1'b0);
            check("t3_hold", ro_result_rb0, 64'h300);
        end
        check("t3_stall", 64'(src_stall_nn0), 64'h2);
        for (int i = 1; i < 4; i++) begin
            idle(1'b1);
            check("t3_drain_v", 64'(ro_valid_rb0), 64'h1);
            check("t3_drain_r", ro_result_rb0, 64'h300 + 64'(i));
        end
        idle(1'b1);
        check("t3_empty", 64'(ro_valid_rb0), 64'h0);

        // Flush with entries queued and the output stage full.
        cyc(2'b11, 64'h400, 64'h500, 1'b0, 1'b0, 1'b0);
        cyc(2'b11, 64'h401, 64'h501, 1'b0, 1'b0, 1'b0);
        cyc(2'b01, 64'h402, 64'h0, 1'b0, 1'b0, 1'b0);
        check("t4_pre_valid", 64'(ro_valid_rb0), 64'h1);
        cyc(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);
        check("t4_valid", 64'(ro_valid_rb0), 64'h0);
        check("t4_stall", 64'(src_stall_nn0), 64'h0);
        cyc(2'b01, 64'h777, 0, 1'b1, 1'b0, 1'b0);
        check("t4_lat", 64'(ro_valid_rb0), 64'h0);
        idle(1'b1);
        check("t4_push_v", 64'(ro_valid_rb0), 64'h1);
        check("t4_push_r", ro_result_rb0, 64'h777);
        idle(1'b1);

        // Overflow: output stage occupied, then five back-to-back src0 pushes.
        cyc(2'b10, 0, 64'h600, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'b01, 64'h700 + 64'(i), 0, 1'b0, 1'b0, 1'b0);
        check("t5_pre", 64'(err_overflow), 64'h0);
        cyc(2'b01, 64'h7FF, 0, 1'b0, 1'b0, 1'b0);
        check("t5_ovf", 64'(err_overflow), 64'h1);
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("t5_sticky", 64'(err_overflow), 64'h1);

        // Reset mid-stream with both FIFOs half full.
        cyc(2'b11, 64'h800, 64'h900, 1'b0, 1'b0, 1'b0);
        cyc(2'b11, 64'h801, 64'h901, 1'b0, 1'b0, 1'b0);
        cyc(2'b11, 64'h802, 64'h902, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
        check("t6_valid", 64'(ro_valid_rb0), 64'h0);
        check("t6_result", ro_result_rb0, 64'h0);
        check("t6_stall", 64'(src_stall_nn0), 64'h0);
        check("t6_err", 64'(err_overflow), 64'h0);
        cyc(2'b01, 64'hBEEF, 0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("t6_push_v", 64'(ro_valid_rb0), 64'h1);
        check("t6_push_r", ro_result_rb0, 64'hBEEF);

        // Randomized traffic; sources mostly honour stall, occasionally not.
        for (int i = 0; i < 2000; i++) begin
            for (int s = 0; s < NS; s++) begin
                v[s] = ($urandom_range(0, 99) < 60) &&
                       (mq[s].size() < DEPTH - 1 || $urandom_range(0, 19) == 0);
            end
            cyc(v, {$urandom, $urandom}, {$urandom, $urandom},
                ($urandom_range(0, 99) < 70), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
